// File: rtl/ffe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ffe_pkg
//  Purpose  : Shared helpers for the parameterised feed-forward equaliser:
//             ceil-log2, accumulator width derivation, commit FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package ffe_pkg;

    // Ceil-log2, never less than 1 so address ports always have a bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Accumulator width: full product plus growth for summing every tap.
    function automatic int acc_bw(input int data_bw, input int coef_bw, input int n_coef);
        return data_bw + coef_bw + clog2(n_coef);
    endfunction

    // Coefficient commit sequencing.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_APPLY = 2'd2
    } commit_state_e;

endpackage
`default_nettype wire

// File: rtl/ffe_coef_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ffe_coef_bank
//  Purpose  : Shadow and active coefficient banks with a commit FSM that
//             swaps the whole active bank on a single clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module ffe_coef_bank
    import ffe_pkg::*;
#(
    parameter int COEF_BW   = 9,
    parameter int N_COEF    = 7,
    parameter int OUT_SHIFT = 7
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_en,
    input  logic                             i_coef_wr,
    input  logic [clog2(N_COEF)-1:0]         i_coef_addr,
    input  logic signed [COEF_BW-1:0]        i_coef_data,
    input  logic                             i_coef_commit,
    output logic                             o_coef_busy,
    output logic [N_COEF-1:0][COEF_BW-1:0]   o_coef
);

    // Tap 0 defaults to unity gain after the output shift, limited to the
    // largest positive coefficient, so a freshly reset filter passes data.
    localparam int c_coef_max = (1 << (COEF_BW - 1)) - 1;
    localparam int c_tap0_int = ((1 << OUT_SHIFT) > c_coef_max) ? c_coef_max : (1 << OUT_SHIFT);
    localparam logic [COEF_BW-1:0] c_tap0 = c_tap0_int[COEF_BW-1:0];
    localparam logic [N_COEF-1:0][COEF_BW-1:0] c_default_bank =
        {{((N_COEF - 1) * COEF_BW){1'b0}}, c_tap0};

    logic [N_COEF-1:0][COEF_BW-1:0] shadow_q;
    logic [N_COEF-1:0][COEF_BW-1:0] active_q;
    commit_state_e                  state_q;
    logic                           busy_q;
    logic                           addr_ok;

    // Addresses past the last tap are silently dropped.
    assign addr_ok = (32'(i_coef_addr) < N_COEF);

    // Shadow bank: host-visible staging area for the next coefficient set.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow_q <= c_default_bank;
        end else if (i_coef_wr && addr_ok) begin
            shadow_q[i_coef_addr] <= i_coef_data;
        end
    end

    // Commit FSM: waits for a write-free or idle cycle, then copies every tap at once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            active_q <= c_default_bank;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_coef_commit) begin
                        state_q <= ST_PEND;
                        busy_q  <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (!(i_en && i_coef_wr)) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    active_q <= shadow_q;
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_coef      = active_q;
    assign o_coef_busy = busy_q;

endmodule
`default_nettype wire

// File: rtl/ffe_param.sv
`default_nettype none
// ============================================================================
//  Module   : ffe_param
//  Purpose  : Transposed-form FIR equaliser with full-precision partial sums,
//             shifted and saturated registered output, and a double-buffered
//             coefficient bank.
//  Revision : 1.0 - initial release
// ============================================================================
module ffe_param
    import ffe_pkg::*;
#(
    parameter int DATA_BW   = 11,
    parameter int COEF_BW   = 9,
    parameter int N_COEF    = 7,
    parameter int OUT_BW    = 9,
    parameter int OUT_SHIFT = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_en,
    input  logic signed [DATA_BW-1:0]    i_data,
    output logic signed [OUT_BW-1:0]     o_data,
    output logic                         o_valid,
    output logic                         o_sat,
    input  logic                         i_coef_wr,
    input  logic [clog2(N_COEF)-1:0]     i_coef_addr,
    input  logic signed [COEF_BW-1:0]    i_coef_data,
    input  logic                         i_coef_commit,
    output logic                         o_coef_busy
);

    localparam int c_prod_bw = DATA_BW + COEF_BW;
    localparam int c_acc_bw  = acc_bw(DATA_BW, COEF_BW, N_COEF);
    localparam logic signed [c_acc_bw-1:0] c_out_max = c_acc_bw'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [c_acc_bw-1:0] c_out_min = c_acc_bw'(-(1 << (OUT_BW - 1)));

    logic [N_COEF-1:0][COEF_BW-1:0]  coef;
    logic signed [c_prod_bw-1:0]     prod   [N_COEF];
    logic signed [c_acc_bw-1:0]      psum_q [1:N_COEF-1];
    logic signed [c_acc_bw-1:0]      psum_d [1:N_COEF-1];
    logic signed [c_acc_bw-1:0]      acc;
    logic signed [c_acc_bw-1:0]      shifted;
    logic signed [OUT_BW-1:0]        data_d;
    logic                            sat_d;
    logic signed [OUT_BW-1:0]        data_q;
    logic                            valid_q;
    logic                            sat_q;

    ffe_coef_bank #(
        .COEF_BW   (COEF_BW),
        .N_COEF    (N_COEF),
        .OUT_SHIFT (OUT_SHIFT)
    ) u_coef_bank (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_coef_wr     (i_coef_wr),
        .i_coef_addr   (i_coef_addr),
        .i_coef_data   (i_coef_data),
        .i_coef_commit (i_coef_commit),
        .o_coef_busy   (o_coef_busy),
        .o_coef        (coef)
    );

    // Every tap multiplies the same new sample by one active coefficient;
    // each partial sum adds its product to the next-older partial sum.
    always_comb begin
        for (int k = 0; k < N_COEF; k++) begin
            prod[k] = c_prod_bw'(i_data) * c_prod_bw'($signed(coef[k]));
        end
        psum_d[N_COEF-1] = c_acc_bw'(prod[N_COEF-1]);
        for (int k = 1; k < N_COEF - 1; k++) begin
            psum_d[k] = c_acc_bw'(prod[k]) + psum_q[k+1];
        end
        acc     = c_acc_bw'(prod[0]) + psum_q[1];
        shifted = acc >>> OUT_SHIFT;
        sat_d   = 1'b0;
        data_d  = shifted[OUT_BW-1:0];
        if (shifted > c_out_max) begin
            data_d = c_out_max[OUT_BW-1:0];
            sat_d  = 1'b1;
        end else if (shifted < c_out_min) begin
            data_d = c_out_min[OUT_BW-1:0];
            sat_d  = 1'b1;
        end
    end

    // Filter state and output register advance only on valid input samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 1; k < N_COEF; k++) psum_q[k] <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            valid_q <= i_en;
            sat_q   <= i_en & sat_d;
            if (i_en) begin
                for (int k = 1; k < N_COEF; k++) psum_q[k] <= psum_d[k];
                data_q <= data_d;
            end
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ffe_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ffe_param
//  Purpose  : Scoreboard bench for ffe_param. A convolution model over the
//             sample history (each sample remembers the bank it entered with)
//             produces expected outputs; a monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ffe_param;

    localparam int DATA_BW   = 11;
    localparam int COEF_BW   = 9;
    localparam int N_COEF    = 7;
    localparam int OUT_BW    = 9;
    localparam int OUT_SHIFT = 7;
    localparam int AW        = 3;
    localparam int OMAX      = (1 << (OUT_BW - 1)) - 1;
    localparam int OMIN      = -(1 << (OUT_BW - 1));
    localparam int CMAX      = (1 << (COEF_BW - 1)) - 1;
    localparam int TAP0      = ((1 << OUT_SHIFT) > CMAX) ? CMAX : (1 << OUT_SHIFT);

    logic                        i_clk = 1'b0;
    logic                        i_rst = 1'b1;
    logic                        i_en = 1'b0;
    logic signed [DATA_BW-1:0]   i_data = '0;
    logic signed [OUT_BW-1:0]    o_data;
    logic                        o_valid;
    logic                        o_sat;
    logic                        i_coef_wr = 1'b0;
    logic [AW-1:0]               i_coef_addr = '0;
    logic signed [COEF_BW-1:0]   i_coef_data = '0;
    logic                        i_coef_commit = 1'b0;
    logic                        o_coef_busy;

    always #5 i_clk = ~i_clk;

    ffe_param #(
        .DATA_BW   (DATA_BW),
        .COEF_BW   (COEF_BW),
        .N_COEF    (N_COEF),
        .OUT_BW    (OUT_BW),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_en          (i_en),
        .i_data        (i_data),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_sat         (o_sat),
        .i_coef_wr     (i_coef_wr),
        .i_coef_addr   (i_coef_addr),
        .i_coef_data   (i_coef_data),
        .i_coef_commit (i_coef_commit),
        .o_coef_busy   (o_coef_busy)
    );

    typedef struct {
        int data;
        bit sat;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   exp_valid = 1'b0;
    bit   exp_busy  = 1'b0;
    int   last_data = 0;
    bit   mon_on    = 1'b0;

    // Reference state: banks, commit progress, and sample history where
    // hx[k] is the sample k steps old and hc[k] the bank it entered with.
    int shadow [N_COEF];
    int active [N_COEF];
    int hx     [N_COEF];
    int hc     [N_COEF][N_COEF];
    bit m_pend  = 1'b0;
    bit m_apply = 1'b0;

    task automatic model_reset();
        for (int k = 0; k < N_COEF; k++) begin
            shadow[k] = (k == 0) ? TAP0 : 0;
            active[k] = (k == 0) ? TAP0 : 0;
            hx[k] = 0;
            for (int j = 0; j < N_COEF; j++) hc[k][j] = 0;
        end
        m_pend    = 1'b0;
        m_apply   = 1'b0;
        exp_valid = 1'b0;
        exp_busy  = 1'b0;
        last_data = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit rst, input bit en, input int x, input bit wr,
                              input int addr, input int cd, input bit cm);
        int y;
        int sh;
        exp_t e;
        if (rst) begin
            model_reset();
            return;
        end
        exp_valid = en;
        if (en) begin
            for (int k = N_COEF - 1; k > 0; k--) begin
                hx[k] = hx[k-1];
                for (int j = 0; j < N_COEF; j++) hc[k][j] = hc[k-1][j];
            end
            hx[0] = x;
            for (int j = 0; j < N_COEF; j++) hc[0][j] = active[j];
            y = 0;
            for (int k = 0; k < N_COEF; k++) y += hc[k][k] * hx[k];
            sh = y >>> OUT_SHIFT;
            e.sat  = (sh > OMAX) || (sh < OMIN);
            e.data = (sh > OMAX) ? OMAX : ((sh < OMIN) ? OMIN : sh);
            exp_q.push_back(e);
        end
        if (m_apply) begin
            for (int j = 0; j < N_COEF; j++) active[j] = shadow[j];
            m_apply = 1'b0;
        end else if (m_pend) begin
            if (!(en && wr)) begin
                m_pend  = 1'b0;
                m_apply = 1'b1;
            end
        end else if (cm) begin
            m_pend = 1'b1;
        end
        if (wr && addr < N_COEF) shadow[addr] = cd;
        exp_busy = m_pend || m_apply;
    endtask

    // One clock of stimulus: inputs change on the falling edge, model follows.
    task automatic drive(input bit rst, input bit en, input int x, input bit wr,
                         input int addr, input int cd, input bit cm);
        @(negedge i_clk);
        i_rst         = rst;
        i_en          = en;
        i_data        = DATA_BW'(x);
        i_coef_wr     = wr;
        i_coef_addr   = AW'(addr);
        i_coef_data   = COEF_BW'(cd);
        i_coef_commit = cm;
        model_edge(rst, en, x, wr, addr, cd, cm);
        mon_on = 1'b1;
    endtask

    task automatic load_bank(input int val_base, input int step);
        for (int k = 0; k < N_COEF; k++) drive(0, 0, 0, 1, k, val_base + step * k, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(0, 2047)) - 1024;
    endfunction

    function automatic int rnd_c();
        return int'($urandom_range(0, 511)) - 256;
    endfunction

    // Monitor: one sample per clock, just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (mon_on) begin
                checks++;
                if (o_coef_busy !== exp_busy) begin
                    errors++;
                    $display("FAIL busy t=%0t got %b want %b", $time, o_coef_busy, exp_busy);
                end
                checks++;
                if (o_valid !== exp_valid) begin
                    errors++;
                    $display("FAIL valid t=%0t got %b want %b", $time, o_valid, exp_valid);
                end
                if (o_valid === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output t=%0t got %0d want none", $time, o_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_data !== OUT_BW'(e.data)) begin
                            errors++;
                            $display("FAIL data t=%0t got %0d want %0d", $time, o_data, e.data);
                        end
                        checks++;
                        if (o_sat !== e.sat) begin
                            errors++;
                            $display("FAIL sat t=%0t got %b want %b", $time, o_sat, e.sat);
                        end
                        last_data = e.data;
                    end
                end else begin
                    checks++;
                    if (o_data !== OUT_BW'(last_data)) begin
                        errors++;
                        $display("FAIL hold t=%0t got %0d want %0d", $time, o_data, last_data);
                    end
                    checks++;
                    if (o_sat !== 1'b0) begin
                        errors++;
                        $display("FAIL sat_idle t=%0t got %b want 0", $time, o_sat);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        // Reset state.
        repeat (3) drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);

        // Default bank: impulse passes through tap 0 only.
        drive(0, 1, 100, 0, 0, 0, 0);
        repeat (8) drive(0, 1, 0, 0, 0, 0, 0);

        // Taps 16, 32, ... 112: impulse walks through each tap.
        load_bank(16, 16);
        drive(0, 1, 64, 0, 0, 0, 0);
        repeat (8) drive(0, 1, 0, 0, 0, 0, 0);

        // Gapped i_en (1-0-0-1) with junk data on idle cycles.
        for (int i = 0; i < 24; i++) begin
            drive(0, (i % 4 == 0) || (i % 4 == 3), (i == 0) ? 64 : ((i % 4 == 0) || (i % 4 == 3) ? 0 : rnd_x()),
                  0, 0, 0, 0);
        end

        // All taps at maximum: positive and negative saturation.
        load_bank(255, 0);
        repeat (10) drive(0, 1, 1023, 0, 0, 0, 0);
        repeat (10) drive(0, 1, -1024, 0, 0, 0, 0);
        repeat (4) drive(0, 1, 0, 0, 0, 0, 0);

        // Commit during streaming: commit with a write, writes hold PEND,
        // a second commit while busy, then a write-free cycle applies.
        drive(0, 1, rnd_x(), 1, 0, 20, 0);
        drive(0, 1, rnd_x(), 1, 1, -30, 1);
        drive(0, 1, rnd_x(), 1, 2, 40, 0);
        drive(0, 1, rnd_x(), 1, 3, -50, 1);
        drive(0, 1, rnd_x(), 0, 0, 0, 1);
        repeat (12) drive(0, 1, rnd_x(), 0, 0, 0, 0);

        // Reset while a commit is pending.
        drive(0, 0, 0, 1, 4, 77, 1);
        drive(0, 1, 300, 1, 5, 88, 0);
        drive(1, 1, 500, 1, 6, 99, 1);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 100, 0, 0, 0, 0);
        repeat (8) drive(0, 1, 0, 0, 0, 0, 0);

        // Randomised traffic, including out-of-range addresses and resets.
        for (int i = 0; i < 1500; i++) begin
            x = rnd_x();
            drive(($urandom % 250) == 0, ($urandom % 4) != 0, x, ($urandom % 3) == 0,
                  int'($urandom_range(0, 7)), rnd_c(), ($urandom % 25) == 0);
        end
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0);

        @(posedge i_clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
